// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: forward-select codes, slot field widths, mult/div latencies.
// Imported by the hazard controller, its interface and the mult/div busy counter.
package mips_defs;

   localparam int ADDR_W       = 5;
   localparam int TNEW_W       = 2;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [TNEW_W-1:0] tnew_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_E  = 2'd1,
      FWD_M  = 2'd2,
      FWD_W  = 2'd3
   } fwd_sel_e;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   typedef struct packed {
      reg_addr_t waddr;
      tnew_t     tnew;
      reg_addr_t rs;
      reg_addr_t rt;
      logic      md_start;
      logic      md_div;
   } e_slot_t;

   typedef struct packed {
      reg_addr_t waddr;
      tnew_t     tnew;
      reg_addr_t rt;
   } m_slot_t;

   // $0 is hard-wired, so a write to it never produces anything worth forwarding or waiting for.
   function automatic logic addr_hit(reg_addr_t src, reg_addr_t dst);
      return (src != '0) && (src == dst);
   endfunction

   function automatic tnew_t tnew_dec(tnew_t t);
      return (t == '0) ? '0 : t - tnew_t'(1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage hazard inputs and stall/forward/busy outputs between the pipeline and the hazard controller.
interface hazard_ctrl_if;
   import mips_defs::*;

   reg_addr_t  rs_D;
   reg_addr_t  rt_D;
   logic [1:0] tuse_rs_D;
   logic [1:0] tuse_rt_D;
   reg_addr_t  waddr_D;
   tnew_t      tnew_D;
   logic       md_D;
   logic       md_start_D;
   logic       md_div_D;

   logic       stall;
   logic       flush_E;
   logic [1:0] fwd_rs_D;
   logic [1:0] fwd_rt_D;
   logic [1:0] fwd_rs_E;
   logic [1:0] fwd_rt_E;
   logic       fwd_rt_M;
   logic       md_busy;

   modport master (
      output rs_D, rt_D, tuse_rs_D, tuse_rt_D, waddr_D, tnew_D, md_D, md_start_D, md_div_D,
      input  stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
   );

   modport slave (
      input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, waddr_D, tnew_D, md_D, md_start_D, md_div_D,
      output stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
   );

endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// HI/LO unit occupancy: busy from the E cycle of mult/div for exactly LAT cycles.
// md_busy_o is combinational on md_start_i; the down-counter covers the remaining LAT-1 cycles.
module md_busy_cnt
   import mips_defs::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_i,
   input  logic md_div_i,
   output logic md_busy_o
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (md_start_i) begin
         cnt_d = md_div_i ? DIV_LOAD : MULT_LOAD;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy_o = md_start_i | (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow scoreboard E/M/W drives stall/flush and D/E/M forward selects.
// All outputs are combinational from the slots and the D-stage inputs; slots advance every clock.
module hazard_ctrl
   import mips_defs::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hz
);

   e_slot_t   e_q, e_d;
   m_slot_t   m_q, m_d;
   reg_addr_t w_waddr_q, w_waddr_d;

   logic stall_rs, stall_rt, stall_md, stall, md_busy;

   // A consumer waits only if its use point comes before the producer's remaining Tnew.
   function automatic logic data_stall(reg_addr_t src, logic [1:0] tuse,
                                       reg_addr_t wa_e, tnew_t tn_e,
                                       reg_addr_t wa_m, tnew_t tn_m);
      return (src != '0) &&
             (((src == wa_e) && (tuse < tn_e)) || ((src == wa_m) && (tuse < tn_m)));
   endfunction

   function automatic logic [1:0] sel3(reg_addr_t src, reg_addr_t wa_e,
                                       reg_addr_t wa_m, reg_addr_t wa_w);
      if (addr_hit(src, wa_e)) return FWD_E;
      if (addr_hit(src, wa_m)) return FWD_M;
      if (addr_hit(src, wa_w)) return FWD_W;
      return FWD_RF;
   endfunction

   function automatic logic [1:0] sel2(reg_addr_t src, reg_addr_t wa_m, reg_addr_t wa_w);
      if (addr_hit(src, wa_m)) return FWD_M;
      if (addr_hit(src, wa_w)) return FWD_W;
      return FWD_RF;
   endfunction

   assign stall_rs = data_stall(hz.rs_D, hz.tuse_rs_D, e_q.waddr, e_q.tnew, m_q.waddr, m_q.tnew);
   assign stall_rt = data_stall(hz.rt_D, hz.tuse_rt_D, e_q.waddr, e_q.tnew, m_q.waddr, m_q.tnew);
   assign stall_md = hz.md_D & md_busy;
   assign stall    = stall_rs | stall_rt | stall_md;

   always_comb begin
      e_d = '0;
      if (!stall) begin
         e_d.waddr    = hz.waddr_D;
         e_d.tnew     = hz.tnew_D;
         e_d.rs       = hz.rs_D;
         e_d.rt       = hz.rt_D;
         e_d.md_start = hz.md_start_D;
         e_d.md_div   = hz.md_div_D;
      end
      m_d.waddr = e_q.waddr;
      m_d.tnew  = tnew_dec(e_q.tnew);
      m_d.rt    = e_q.rt;
      w_waddr_d = m_q.waddr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q       <= '0;
         m_q       <= '0;
         w_waddr_q <= '0;
      end else begin
         e_q       <= e_d;
         m_q       <= m_d;
         w_waddr_q <= w_waddr_d;
      end
   end

   md_busy_cnt #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy_cnt (
      .clk        (clk),
      .reset      (reset),
      .md_start_i (e_q.md_start),
      .md_div_i   (e_q.md_div),
      .md_busy_o  (md_busy)
   );

   assign hz.stall    = stall;
   assign hz.flush_E  = stall;
   assign hz.md_busy  = md_busy;
   assign hz.fwd_rs_D = sel3(hz.rs_D, e_q.waddr, m_q.waddr, w_waddr_q);
   assign hz.fwd_rt_D = sel3(hz.rt_D, e_q.waddr, m_q.waddr, w_waddr_q);
   assign hz.fwd_rs_E = sel2(e_q.rs, m_q.waddr, w_waddr_q);
   assign hz.fwd_rt_E = sel2(e_q.rt, m_q.waddr, w_waddr_q);
   assign hz.fwd_rt_M = addr_hit(m_q.rt, w_waddr_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, reset-mid-divide sequence, random run vs a cycle-history model.
module tb_hazard_ctrl;
   import mips_defs::*;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] tuse_rs;
      logic [1:0] tuse_rt;
      logic [4:0] waddr;
      logic [1:0] tnew;
      logic       md;
      logic       md_start;
      logic       md_div;
   } din_t;

   typedef struct packed {
      logic       stall;
      logic       flush;
      logic [1:0] frs_d;
      logic [1:0] frt_d;
      logic [1:0] frs_e;
      logic [1:0] frt_e;
      logic       frt_m;
      logic       busy;
   } exp_t;

   typedef struct {
      din_t d;
      exp_t e;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   din_t d_cur = '0;

   always #5 clk = ~clk;

   hazard_ctrl_if hif();

   assign hif.rs_D       = d_cur.rs;
   assign hif.rt_D       = d_cur.rt;
   assign hif.tuse_rs_D  = d_cur.tuse_rs;
   assign hif.tuse_rt_D  = d_cur.tuse_rt;
   assign hif.waddr_D    = d_cur.waddr;
   assign hif.tnew_D     = d_cur.tnew;
   assign hif.md_D       = d_cur.md;
   assign hif.md_start_D = d_cur.md_start;
   assign hif.md_div_D   = d_cur.md_div;

   hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hif)
   );

   int compared = 0;
   int mismatched = 0;

   // Model: ent[c] is the instruction that occupied E in cycle c; M and W are just older cycles.
   din_t ent [0:4095];
   int   now = 2;
   int   md_start_cyc = -100;
   int   md_lat = 0;

   function automatic din_t ins(input int rs, rt, trs, trt, wa, tn,
                                input int md = 0, ms = 0, mv = 0);
      din_t x;
      x.rs = 5'(rs); x.rt = 5'(rt); x.tuse_rs = 2'(trs); x.tuse_rt = 2'(trt);
      x.waddr = 5'(wa); x.tnew = 2'(tn);
      x.md = 1'(md); x.md_start = 1'(ms); x.md_div = 1'(mv);
      return x;
   endfunction

   function automatic exp_t ex(input int st, frsd, frtd, frse, frte, frtm, busy);
      exp_t x;
      x.stall = 1'(st); x.flush = 1'(st);
      x.frs_d = 2'(frsd); x.frt_d = 2'(frtd); x.frs_e = 2'(frse); x.frt_e = 2'(frte);
      x.frt_m = 1'(frtm); x.busy = 1'(busy);
      return x;
   endfunction

   // Cycles still needed before a producer that entered E 'age' cycles ago has its result.
   function automatic int remaining(input din_t p, input int age);
      int r;
      r = int'(p.tnew) - age;
      return (r < 0) ? 0 : r;
   endfunction

   function automatic logic [1:0] nearest(input logic [4:0] a, input int first_age);
      for (int age = first_age; age <= 2; age++) begin
         if (a != 5'd0 && ent[now-age].waddr == a) return 2'(age + 1);
      end
      return 2'd0;
   endfunction

   function automatic logic must_wait(input logic [4:0] a, input logic [1:0] tuse);
      if (a == 5'd0) return 1'b0;
      for (int age = 0; age <= 1; age++) begin
         if (ent[now-age].waddr == a && int'(tuse) < remaining(ent[now-age], age)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic exp_t model(input din_t d);
      exp_t x;
      logic busy;
      busy = (md_start_cyc >= 0) && (now >= md_start_cyc) && (now < md_start_cyc + md_lat);
      x.stall = must_wait(d.rs, d.tuse_rs) | must_wait(d.rt, d.tuse_rt) | (d.md & busy);
      x.flush = x.stall;
      x.frs_d = nearest(d.rs, 0);
      x.frt_d = nearest(d.rt, 0);
      x.frs_e = nearest(ent[now].rs, 1);
      x.frt_e = nearest(ent[now].rt, 1);
      x.frt_m = (ent[now-1].rt != 5'd0) && (ent[now-1].rt == ent[now-2].waddr);
      x.busy  = busy;
      return x;
   endfunction

   task automatic model_clear();
      for (int i = 0; i <= 2; i++) ent[now-i] = '0;
      md_start_cyc = -100;
   endtask

   task automatic tick();
      exp_t m;
      @(posedge clk);
      if (reset) begin
         m = model(d_cur);
         now++;
         ent[now] = m.stall ? din_t'('0) : d_cur;
         if (!m.stall && d_cur.md_start) begin
            md_start_cyc = now;
            md_lat = d_cur.md_div ? 10 : 5;
         end
      end
   endtask

   task automatic check(input string tag, input exp_t want);
      exp_t got;
      got.stall = hif.stall;    got.flush = hif.flush_E;
      got.frs_d = hif.fwd_rs_D; got.frt_d = hif.fwd_rt_D;
      got.frs_e = hif.fwd_rs_E; got.frt_e = hif.fwd_rt_E;
      got.frt_m = hif.fwd_rt_M; got.busy  = hif.md_busy;
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s @%0t: got {stall,flush,rsD,rtD,rsE,rtE,rtM,busy}=%b required %b",
                  tag, $time, got, want);
      end
   endtask

   task automatic run_cycle(input din_t d, input exp_t want, input bit use_model, input string tag);
      @(negedge clk);
      d_cur = d;
      #2;
      check(tag, use_model ? model(d) : want);
      tick();
   endtask

   vec_t tbl[$];

   initial begin
      din_t nop, mflo, mult, dv;
      exp_t z;
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      din_t nop, mflo, mult, dv, r;
      exp_t z;
      foreach (ent[i]) ent[i] = '0;
      nop  = ins(0, 0, TUSE_NONE, TUSE_NONE, 0, 0);
      mflo = ins(0, 0, 3, 3, 2, 1, 1, 0, 0);
      mult = ins(0, 0, 3, 3, 0, 0, 1, 1, 0);
      dv   = ins(0, 0, 3, 3, 0, 0, 1, 1, 1);
      z    = ex(0, 0, 0, 0, 0, 0, 0);

      // Load-use
      tbl.push_back('{ins(0, 0, 3, 3, 8, 2), z});
      tbl.push_back('{ins(8, 0, 1, 3, 10, 1), ex(1, 1, 0, 0, 0, 0, 0)});
      tbl.push_back('{ins(8, 0, 1, 3, 10, 1), ex(0, 2, 0, 0, 0, 0, 0)});
      tbl.push_back('{nop, ex(0, 0, 0, 3, 0, 0, 0)});
      repeat (3) tbl.push_back('{nop, z});
      // ALU chain, tuse=1 then tuse=0 consumers
      tbl.push_back('{ins(0, 0, 3, 3, 9, 1), z});
      tbl.push_back('{ins(9, 0, 1, 3, 11, 1), ex(0, 1, 0, 0, 0, 0, 0)});
      tbl.push_back('{ins(9, 0, 0, 3, 0, 0), ex(0, 2, 0, 2, 0, 0, 0)});
      tbl.push_back('{nop, ex(0, 0, 0, 3, 0, 0, 0)});
      tbl.push_back('{ins(0, 0, 3, 3, 12, 1), z});
      tbl.push_back('{ins(12, 0, 0, 3, 0, 0), ex(1, 1, 0, 0, 0, 0, 0)});
      tbl.push_back('{ins(12, 0, 0, 3, 0, 0), ex(0, 2, 0, 0, 0, 0, 0)});
      tbl.push_back('{nop, ex(0, 0, 0, 3, 0, 0, 0)});
      repeat (2) tbl.push_back('{nop, z});
      // M beats W; $0 never matches
      tbl.push_back('{ins(0, 0, 3, 3, 5, 1), z});
      tbl.push_back('{ins(0, 0, 3, 3, 5, 1), z});
      tbl.push_back('{ins(5, 0, 1, 3, 0, 0), ex(0, 1, 0, 0, 0, 0, 0)});
      tbl.push_back('{ins(0, 0, 3, 3, 0, 2), ex(0, 0, 0, 2, 0, 0, 0)});
      tbl.push_back('{ins(0, 0, 0, 0, 0, 0), z});
      repeat (3) tbl.push_back('{nop, z});
      // rs and rt on the same load: one bubble
      tbl.push_back('{ins(0, 0, 3, 3, 7, 2), z});
      tbl.push_back('{ins(7, 7, 1, 1, 0, 0), ex(1, 1, 1, 0, 0, 0, 0)});
      tbl.push_back('{ins(7, 7, 1, 1, 0, 0), ex(0, 2, 2, 0, 0, 0, 0)});
      tbl.push_back('{nop, ex(0, 0, 0, 3, 3, 0, 0)});
      repeat (2) tbl.push_back('{nop, z});
      // mult then mflo; div then back-to-back mult
      tbl.push_back('{mult, z});
      repeat (5) tbl.push_back('{mflo, ex(1, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{mflo, z});
      tbl.push_back('{dv, z});
      repeat (10) tbl.push_back('{mult, ex(1, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{mult, z});
      repeat (5) tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{nop, z});
      // Store data forwarding
      tbl.push_back('{ins(0, 0, 3, 3, 3, 2), z});
      tbl.push_back('{ins(0, 3, 1, 2, 0, 0), ex(0, 0, 1, 0, 0, 0, 0)});
      tbl.push_back('{nop, ex(0, 0, 0, 0, 2, 0, 0)});
      tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 1, 0)});
      tbl.push_back('{nop, z});

      reset = 1'b0;
      d_cur = ins(8, 8, 0, 0, 8, 2, 1, 1, 1);
      repeat (2) @(negedge clk);
      #2;
      check("reset_hold", z);
      @(negedge clk);
      d_cur = nop;
      reset = 1'b1;
      #2;
      check("reset_release", z);
      tick();

      foreach (tbl[i]) run_cycle(tbl[i].d, tbl[i].e, 1'b0, $sformatf("vec%0d", i));

      // Reset while the divider counter sits at 6
      run_cycle(dv, z, 1'b1, "pre_div");
      repeat (4) run_cycle(mflo, z, 1'b1, "div_wait");
      @(negedge clk);
      d_cur = ins(3, 3, 0, 0, 2, 1, 1, 0, 0);
      #2;
      check("mid_div", ex(1, 0, 0, 0, 0, 0, 1));
      reset = 1'b0;
      model_clear();
      #1;
      check("reset_async", z);
      @(negedge clk);
      #2;
      check("reset_held_div", z);
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("reset_after_div", z);
      tick();
      repeat (2) run_cycle(d_cur, z, 1'b0, "post_reset");

      for (int n = 0; n < 1500; n++) begin
         r.rs       = 5'($urandom_range(0, 7));
         r.rt       = 5'($urandom_range(0, 7));
         r.tuse_rs  = 2'($urandom_range(0, 3));
         r.tuse_rt  = 2'($urandom_range(0, 3));
         r.waddr    = 5'($urandom_range(0, 7));
         r.tnew     = 2'($urandom_range(0, 2));
         r.md       = ($urandom_range(0, 7) == 0);
         r.md_start = r.md & 1'($urandom_range(0, 1));
         r.md_div   = 1'($urandom_range(0, 1));
         run_cycle(r, z, 1'b1, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
